programm_lader: RTL and testbench
=================================

PROGRAMM_LADER -- requirements
Module: programm_lader

Interface
REQ-001 The block SHALL take parameter ABSTAND, default 31, meaning the idle cycles enforced between the end of one SD word read and the next SDLesen pulse.
REQ-002 The block SHALL take parameter RAM_WORDS, default 32768, meaning the RAM capacity in 32-bit words.
REQ-003 The block SHALL have the port Clock, input, 1 bit, the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 The block SHALL have the port Reset, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have the port Start, input, 1 bit, a one-cycle request to begin loading.
REQ-006 The block SHALL have the port SDAdresse, output, 32 bits, the SD word address.
REQ-007 The block SHALL have the port SDLesen, output, 1 bit, the read request pulse to SDKarte.
REQ-008 The block SHALL have the port SDBusy, input, 1 bit, the SD reader busy flag.
REQ-009 The block SHALL have the port SDDaten, input, 32 bits, the SD read word, valid when SDBusy falls.
REQ-010 The block SHALL have the port RAMAdresse, output, 32 bits, the RAM word address.
REQ-011 The block SHALL have the port RAMDaten, output, 32 bits, the RAM write data.
REQ-012 The block SHALL have the port RAMSchreiben, output, 1 bit, the RAM write request.
REQ-013 The block SHALL have the port RAMGeschrieben, input, 1 bit, the RAM write acknowledge.
REQ-014 The block SHALL have the port CPUReset, output, 1 bit; 1 holds the CPU in reset.
REQ-015 The block SHALL have the ports Fertig (output, 1 bit), Fehler (output, 1 bit) and Zustand (output, 3 bits, the state code for LEDs).

Function
REQ-016 The state machine SHALL have these states: LEERLAUF=0, GROESSE_ANFORDERN=1, SD_WARTEN=2, PAUSE=3, RAM_SCHREIBEN=4, FERTIG=5, FEHLER=6; Zustand SHALL equal the current state code.
REQ-017 In LEERLAUF, Start=1 SHALL set SDAdresse=0, pulse SDLesen for exactly one cycle, and enter SD_WARTEN; Start in any other state SHALL be ignored.
REQ-018 SD_WARTEN handshake: the block SHALL first wait for SDBusy=1, then for SDBusy=0, and SHALL capture SDDaten on the cycle SDBusy is sampled low after having been high.
REQ-019 The first captured word SHALL be N, the program length in words, and SHALL be stored in a 32-bit register Menge.
REQ-020 If N=0 the block SHALL enter FERTIG; if N>RAM_WORDS it SHALL enter FEHLER; otherwise it SHALL enter PAUSE.
REQ-021 PAUSE SHALL last exactly ABSTAND cycles, counted with a counter of width clog2(ABSTAND+1), and SHALL then issue SDLesen for the next word at SDAdresse=k+1, for k=0..N-1.
REQ-022 Each data word k SHALL enter RAM_SCHREIBEN with RAMAdresse=k and RAMDaten=the captured word; RAMSchreiben, RAMAdresse and RAMDaten SHALL be held stable until RAMGeschrieben=1 is sampled.
REQ-023 RAMSchreiben SHALL deassert on the cycle after the acknowledge; a RAMGeschrieben pulse outside RAM_SCHREIBEN SHALL be ignored.
REQ-024 After the acknowledge, the block SHALL enter PAUSE if k+1<N, else FERTIG.
REQ-025 In FERTIG the block SHALL set Fertig=1 and CPUReset=0; FERTIG is terminal until reset.
REQ-026 In FEHLER the block SHALL set Fehler=1 and CPUReset=1; FEHLER is sticky until reset.
REQ-027 CPUReset SHALL be 1 in every state except FERTIG.
REQ-028 SDLesen and RAMSchreiben SHALL never both be 1 in the same cycle.
REQ-029 The word index k SHALL be a 32-bit counter; no wrap is reachable because N≤RAM_WORDS.

Reset
REQ-030 While Reset=0, the block SHALL set state=LEERLAUF and drive SDLesen=0, RAMSchreiben=0, SDAdresse=0, RAMAdresse=0, RAMDaten=0, Fertig=0, Fehler=0 and CPUReset=1, and SHALL clear Menge, k and the pause counter.
REQ-031 A reset asserted mid-load SHALL abort the load immediately, with no further RAM writes after release until the next Start.

Structure
REQ-032 The state codes and the default ABSTAND and RAM_WORDS values SHALL reside in a shared package, lader_pkg, which Top also uses for its LED display.
REQ-033 The SD request/wait handshake SHALL be a sub-module named sd_wort_anfrage (inputs: request and address; outputs: word-valid pulse and data); everything else SHALL stay in programm_lader.

Verification
REQ-034 The bench SHALL cover: SD model with N=3 and words A1,B2,C3 -> RAM[0..2]=A1,B2,C3, then Fertig=1 and CPUReset=0; with ABSTAND=31, consecutive SDLesen pulses SHALL be ≥31 cycles apart.
REQ-035 The bench SHALL cover: N=0 -> FERTIG with no RAMSchreiben ever asserted.
REQ-036 The bench SHALL cover: N=RAM_WORDS+1 -> Fehler=1, CPUReset=1, Zustand=6, and no RAM writes.
REQ-037 The bench SHALL cover: RAMGeschrieben delayed 5 cycles -> RAMSchreiben, RAMAdresse and RAMDaten stable for all 5 cycles, and no SDLesen during that time.
REQ-038 The bench SHALL cover: Reset low during word 2 of N=4 -> outputs at reset values within the same cycle; a new Start SHALL reload from SDAdresse=0.
REQ-039 The bench SHALL cover: Start pulsed repeatedly during a load -> ignored, with the address sequence unchanged.

Source files
------------

// File: rtl/lader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lader_pkg
//  Description : Shared state codes and default sizing for the program loader
//                (also used by the board top for its LED state display).
//  Revision    : 1.0  initial release
// ============================================================================
package lader_pkg;

    // Idle cycles between the end of one SD word read and the next request
    localparam int C_ABSTAND_DEFAULT   = 31;
    // RAM capacity in 32-bit words
    localparam int C_RAM_WORDS_DEFAULT = 32768;

    // Loader state codes; the numeric value is shown on the LEDs
    typedef enum logic [2:0] {
        LEERLAUF          = 3'd0,
        GROESSE_ANFORDERN = 3'd1,
        SD_WARTEN         = 3'd2,
        PAUSE             = 3'd3,
        RAM_SCHREIBEN     = 3'd4,
        FERTIG            = 3'd5,
        FEHLER            = 3'd6
    } zustand_t;

    // Phases of a single SD word request
    typedef enum logic [1:0] {
        PH_BEREIT        = 2'd0,
        PH_WARTE_HOCH    = 2'd1,
        PH_WARTE_NIEDRIG = 2'd2
    } anfrage_phase_t;

endpackage
`default_nettype wire

// File: rtl/programm_lader_if.sv
`default_nettype none
// ============================================================================
//  Module      : programm_lader_if
//  Description : SD-reader and RAM-write bus between the program loader
//                (master) and the SD card reader / RAM controller (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface programm_lader_if;

    logic [31:0] SDAdresse;
    logic        SDLesen;
    logic        SDBusy;
    logic [31:0] SDDaten;
    logic [31:0] RAMAdresse;
    logic [31:0] RAMDaten;
    logic        RAMSchreiben;
    logic        RAMGeschrieben;

    modport master (
        output SDAdresse, SDLesen, RAMAdresse, RAMDaten, RAMSchreiben,
        input  SDBusy, SDDaten, RAMGeschrieben
    );

    modport slave (
        input  SDAdresse, SDLesen, RAMAdresse, RAMDaten, RAMSchreiben,
        output SDBusy, SDDaten, RAMGeschrieben
    );

endinterface
`default_nettype wire

// File: rtl/sd_wort_anfrage.sv
`default_nettype none
// ============================================================================
//  Module      : sd_wort_anfrage
//  Description : Issues a one-cycle SDLesen pulse with its address, waits for
//                the reader to go busy and then idle again, and returns the
//                word captured on the falling busy edge with a valid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module sd_wort_anfrage
    import lader_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        i_anfrage,
    input  logic [31:0] i_adresse,
    input  logic        i_sd_busy,
    input  logic [31:0] i_sd_daten,
    output logic        o_sd_lesen,
    output logic [31:0] o_sd_adresse,
    output logic        o_wort_gueltig,
    output logic [31:0] o_wort
);

    anfrage_phase_t phase_q, phase_d;
    logic           sd_lesen_q, sd_lesen_d;
    logic [31:0]    sd_adresse_q, sd_adresse_d;
    logic           gueltig_q, gueltig_d;
    logic [31:0]    wort_q, wort_d;

    // Request/handshake register bank
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            phase_q      <= PH_BEREIT;
            sd_lesen_q   <= 1'b0;
            sd_adresse_q <= 32'd0;
            gueltig_q    <= 1'b0;
            wort_q       <= 32'd0;
        end else begin
            phase_q      <= phase_d;
            sd_lesen_q   <= sd_lesen_d;
            sd_adresse_q <= sd_adresse_d;
            gueltig_q    <= gueltig_d;
            wort_q       <= wort_d;
        end
    end

    // Busy must be seen high before its low level counts as end of read
    always_comb begin
        phase_d      = phase_q;
        sd_lesen_d   = 1'b0;
        sd_adresse_d = sd_adresse_q;
        gueltig_d    = 1'b0;
        wort_d       = wort_q;
        case (phase_q)
            PH_BEREIT: begin
                if (i_anfrage) begin
                    sd_lesen_d   = 1'b1;
                    sd_adresse_d = i_adresse;
                    phase_d      = PH_WARTE_HOCH;
                end
            end
            PH_WARTE_HOCH: begin
                if (i_sd_busy) begin
                    phase_d = PH_WARTE_NIEDRIG;
                end
            end
            PH_WARTE_NIEDRIG: begin
                if (!i_sd_busy) begin
                    wort_d    = i_sd_daten;
                    gueltig_d = 1'b1;
                    phase_d   = PH_BEREIT;
                end
            end
            default: phase_d = PH_BEREIT;
        endcase
    end

    assign o_sd_lesen     = sd_lesen_q;
    assign o_sd_adresse   = sd_adresse_q;
    assign o_wort_gueltig = gueltig_q;
    assign o_wort         = wort_q;

endmodule
`default_nettype wire

// File: rtl/programm_lader.sv
`default_nettype none
// ============================================================================
//  Module      : programm_lader
//  Description : Boot loader. Reads the program length N from SD word 0, then
//                copies SD words 1..N into RAM words 0..N-1 with a fixed pause
//                between SD reads, holding the CPU in reset until done.
//                ABSTAND must be at least 1.
//  Revision    : 1.0  initial release
// ============================================================================
module programm_lader
    import lader_pkg::*;
#(
    parameter int ABSTAND   = C_ABSTAND_DEFAULT,
    parameter int RAM_WORDS = C_RAM_WORDS_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    programm_lader_if.master  bus,
    output logic              CPUReset,
    output logic              Fertig,
    output logic              Fehler,
    output logic [2:0]        Zustand
);

    localparam int                 C_CNT_W        = $clog2(ABSTAND + 1);
    localparam logic [C_CNT_W-1:0] C_PAUSE_ENDE   = C_CNT_W'(ABSTAND - 1);
    localparam logic [31:0]        C_RAM_WORDS_32 = 32'(RAM_WORDS);

    zustand_t           state_q, state_d;
    logic [31:0]        menge_q, menge_d;
    logic [31:0]        k_q, k_d;
    logic [C_CNT_W-1:0] pause_cnt_q, pause_cnt_d;
    logic               laenge_da_q, laenge_da_d;
    logic               ram_schreiben_q, ram_schreiben_d;
    logic [31:0]        ram_adresse_q, ram_adresse_d;
    logic [31:0]        ram_daten_q, ram_daten_d;

    logic               w_anfrage;
    logic [31:0]        w_anfrage_adresse;
    logic               w_wort_gueltig;
    logic [31:0]        w_wort;
    logic [31:0]        w_k_plus_1;

    sd_wort_anfrage u_sd_wort_anfrage (
        .Clock          (Clock),
        .Reset          (Reset),
        .i_anfrage      (w_anfrage),
        .i_adresse      (w_anfrage_adresse),
        .i_sd_busy      (bus.SDBusy),
        .i_sd_daten     (bus.SDDaten),
        .o_sd_lesen     (bus.SDLesen),
        .o_sd_adresse   (bus.SDAdresse),
        .o_wort_gueltig (w_wort_gueltig),
        .o_wort         (w_wort)
    );

    assign w_k_plus_1 = k_q + 32'd1;

    // Loader state and datapath registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q         <= LEERLAUF;
            menge_q         <= 32'd0;
            k_q             <= 32'd0;
            pause_cnt_q     <= '0;
            laenge_da_q     <= 1'b0;
            ram_schreiben_q <= 1'b0;
            ram_adresse_q   <= 32'd0;
            ram_daten_q     <= 32'd0;
        end else begin
            state_q         <= state_d;
            menge_q         <= menge_d;
            k_q             <= k_d;
            pause_cnt_q     <= pause_cnt_d;
            laenge_da_q     <= laenge_da_d;
            ram_schreiben_q <= ram_schreiben_d;
            ram_adresse_q   <= ram_adresse_d;
            ram_daten_q     <= ram_daten_d;
        end
    end

    // Next-state logic: size word first, then pause / read / write per word
    always_comb begin
        state_d           = state_q;
        menge_d           = menge_q;
        k_d               = k_q;
        pause_cnt_d       = pause_cnt_q;
        laenge_da_d       = laenge_da_q;
        ram_schreiben_d   = ram_schreiben_q;
        ram_adresse_d     = ram_adresse_q;
        ram_daten_d       = ram_daten_q;
        w_anfrage         = 1'b0;
        w_anfrage_adresse = 32'd0;
        case (state_q)
            LEERLAUF: begin
                if (Start) begin
                    w_anfrage   = 1'b1;
                    laenge_da_d = 1'b0;
                    k_d         = 32'd0;
                    state_d     = SD_WARTEN;
                end
            end
            SD_WARTEN: begin
                if (w_wort_gueltig) begin
                    if (!laenge_da_q) begin
                        laenge_da_d = 1'b1;
                        menge_d     = w_wort;
                        pause_cnt_d = '0;
                        if (w_wort == 32'd0) begin
                            state_d = FERTIG;
                        end else if (w_wort > C_RAM_WORDS_32) begin
                            state_d = FEHLER;
                        end else begin
                            state_d = PAUSE;
                        end
                    end else begin
                        ram_schreiben_d = 1'b1;
                        ram_adresse_d   = k_q;
                        ram_daten_d     = w_wort;
                        state_d         = RAM_SCHREIBEN;
                    end
                end
            end
            PAUSE: begin
                if (pause_cnt_q == C_PAUSE_ENDE) begin
                    pause_cnt_d       = '0;
                    w_anfrage         = 1'b1;
                    w_anfrage_adresse = w_k_plus_1;
                    state_d           = SD_WARTEN;
                end else begin
                    pause_cnt_d = pause_cnt_q + C_CNT_W'(1);
                end
            end
            RAM_SCHREIBEN: begin
                if (bus.RAMGeschrieben) begin
                    ram_schreiben_d = 1'b0;
                    k_d             = w_k_plus_1;
                    state_d         = (w_k_plus_1 < menge_q) ? PAUSE : FERTIG;
                end
            end
            FERTIG, FEHLER: begin
                state_d = state_q;
            end
            default: state_d = LEERLAUF;
        endcase
    end

    assign bus.RAMSchreiben = ram_schreiben_q;
    assign bus.RAMAdresse   = ram_adresse_q;
    assign bus.RAMDaten     = ram_daten_q;

    assign Zustand  = state_q;
    assign Fertig   = (state_q == FERTIG);
    assign Fehler   = (state_q == FEHLER);
    assign CPUReset = (state_q != FERTIG);

endmodule
`default_nettype wire

// File: tb/tb_programm_lader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_programm_lader
//  Description : Directed self-checking bench for programm_lader with a
//                behavioural SD reader and RAM controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_programm_lader;
    import lader_pkg::*;

    localparam int ABSTAND   = 31;
    localparam int RAM_WORDS = 32768;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       CPUReset;
    logic       Fertig;
    logic       Fehler;
    logic [2:0] Zustand;

    programm_lader_if bus ();

    programm_lader #(
        .ABSTAND   (ABSTAND),
        .RAM_WORDS (RAM_WORDS)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .bus      (bus),
        .CPUReset (CPUReset),
        .Fertig   (Fertig),
        .Fehler   (Fehler),
        .Zustand  (Zustand)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] ist, input logic [31:0] soll);
        n_checks++;
        if (ist !== soll) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, ist, soll);
        end
    endtask

    // ---------------- SD reader model ----------------
    logic [31:0] sd_tab [0:7];
    logic [31:0] sd_addr;
    int          sd_rest    = 0;
    logic        lesen_prev = 1'b0;
    logic [31:0] lesen_addr [$];
    int          lesen_cyc  [$];

    // Busy for three cycles after each request, data presented as busy drops
    always @(negedge Clock) begin
        if (!Reset) begin
            bus.SDBusy  = 1'b0;
            bus.SDDaten = 32'd0;
            sd_rest     = 0;
            lesen_prev  = 1'b0;
        end else begin
            if (bus.SDLesen) begin
                check_eq("sdlesen_one_cycle", {31'd0, lesen_prev}, 32'd0);
                lesen_addr.push_back(bus.SDAdresse);
                lesen_cyc.push_back(cyc);
            end
            lesen_prev = bus.SDLesen;
            if (sd_rest > 0) begin
                sd_rest--;
                if (sd_rest == 0) begin
                    bus.SDDaten = sd_tab[sd_addr[2:0]];
                    bus.SDBusy  = 1'b0;
                end
            end else if (bus.SDLesen) begin
                sd_addr    = bus.SDAdresse;
                bus.SDBusy = 1'b1;
                sd_rest    = 3;
            end
        end
    end

    // ---------------- RAM controller model ----------------
    int          ram_delay = 0;
    int          ram_wait  = 0;
    int          hold      = 0;
    int          last_hold = 0;
    int          wr_seen   = 0;
    logic [31:0] h_addr, h_data;
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    // Acknowledge after ram_delay waiting cycles; request must stay stable
    always @(negedge Clock) begin
        if (!Reset) begin
            bus.RAMGeschrieben = 1'b0;
            ram_wait = 0;
            hold     = 0;
        end else if (bus.RAMGeschrieben) begin
            bus.RAMGeschrieben = 1'b0;
            hold = 0;
            check_eq("ramschreiben_drop", {31'd0, bus.RAMSchreiben}, 32'd0);
        end else if (bus.RAMSchreiben) begin
            wr_seen++;
            if (hold == 0) begin
                h_addr = bus.RAMAdresse;
                h_data = bus.RAMDaten;
            end else begin
                check_eq("ramadresse_stable", bus.RAMAdresse, h_addr);
                check_eq("ramdaten_stable", bus.RAMDaten, h_data);
            end
            check_eq("no_sdlesen_during_write", {31'd0, bus.SDLesen}, 32'd0);
            hold++;
            if (ram_wait >= ram_delay) begin
                wr_addr.push_back(bus.RAMAdresse);
                wr_data.push_back(bus.RAMDaten);
                bus.RAMGeschrieben = 1'b1;
                ram_wait  = 0;
                last_hold = hold;
            end else begin
                ram_wait++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_zustand"},    {29'd0, Zustand},          32'd0);
        check_eq({pfx, "_sdlesen"},    {31'd0, bus.SDLesen},      32'd0);
        check_eq({pfx, "_ramschr"},    {31'd0, bus.RAMSchreiben}, 32'd0);
        check_eq({pfx, "_sdadresse"},  bus.SDAdresse,             32'd0);
        check_eq({pfx, "_ramadresse"}, bus.RAMAdresse,            32'd0);
        check_eq({pfx, "_ramdaten"},   bus.RAMDaten,              32'd0);
        check_eq({pfx, "_fertig"},     {31'd0, Fertig},           32'd0);
        check_eq({pfx, "_fehler"},     {31'd0, Fehler},           32'd0);
        check_eq({pfx, "_cpureset"},   {31'd0, CPUReset},         32'd1);
    endtask

    task automatic clear_logs();
        lesen_addr.delete();
        lesen_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        wr_seen = 0;
    endtask

    task automatic do_reset(input string pfx);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        check_reset_outputs(pfx);
        clear_logs();
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    task automatic pulse_start();
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] code, input int budget);
        int n;
        n = 0;
        while (Zustand !== code && n < budget) begin
            @(negedge Clock);
            n++;
        end
        check_eq(tag, {29'd0, Zustand}, {29'd0, code});
    endtask

    task automatic check_writes(input string pfx, input int n, input logic [31:0] basis);
        check_eq({pfx, "_write_count"}, wr_addr.size(), n);
        for (int i = 0; i < n; i++) begin
            check_eq({pfx, "_wr_addr"}, wr_addr[i], i);
            check_eq({pfx, "_wr_data"}, wr_data[i], sd_tab[i + 1]);
        end
        check_eq({pfx, "_first_data"}, wr_data[0], basis);
    endtask

    task automatic check_reads(input string pfx, input int n);
        check_eq({pfx, "_read_count"}, lesen_addr.size(), n);
        for (int i = 0; i < n; i++) begin
            check_eq({pfx, "_rd_addr"}, lesen_addr[i], i);
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int exp_gap [3];
        int n_wr;
        int n_rd;
        exp_gap = '{36, 37, 37};
        for (int i = 0; i < 8; i++) sd_tab[i] = 32'd0;

        // Normal load: N=3, words A1,B2,C3
        sd_tab[0] = 32'd3;
        sd_tab[1] = 32'h0000_00A1;
        sd_tab[2] = 32'h0000_00B2;
        sd_tab[3] = 32'h0000_00C3;
        do_reset("t1_reset");
        check_eq("t1_idle_cpureset", {31'd0, CPUReset}, 32'd1);
        pulse_start();
        wait_state("t1_reach_fertig", FERTIG, 2000);
        check_writes("t1", 3, 32'h0000_00A1);
        check_reads("t1", 4);
        for (int i = 0; i < 3; i++) begin
            check_eq("t1_read_gap", lesen_cyc[i + 1] - lesen_cyc[i], exp_gap[i]);
        end
        check_eq("t1_fertig", {31'd0, Fertig}, 32'd1);
        check_eq("t1_cpureset", {31'd0, CPUReset}, 32'd0);
        check_eq("t1_fehler", {31'd0, Fehler}, 32'd0);
        // Start in FERTIG is ignored
        pulse_start();
        repeat (60) @(negedge Clock);
        check_eq("t1_start_ignored_state", {29'd0, Zustand}, 32'd5);
        check_eq("t1_start_ignored_reads", lesen_addr.size(), 4);

        // Empty program: N=0
        sd_tab[0] = 32'd0;
        do_reset("t2_reset");
        pulse_start();
        wait_state("t2_reach_fertig", FERTIG, 500);
        repeat (5) @(negedge Clock);
        check_eq("t2_no_ramschreiben", wr_seen, 0);
        check_eq("t2_fertig", {31'd0, Fertig}, 32'd1);
        check_eq("t2_cpureset", {31'd0, CPUReset}, 32'd0);
        check_eq("t2_read_count", lesen_addr.size(), 1);

        // Oversized program: N=RAM_WORDS+1
        sd_tab[0] = RAM_WORDS + 1;
        do_reset("t3_reset");
        pulse_start();
        wait_state("t3_reach_fehler", FEHLER, 500);
        repeat (50) @(negedge Clock);
        check_eq("t3_still_fehler", {29'd0, Zustand}, 32'd6);
        check_eq("t3_fehler", {31'd0, Fehler}, 32'd1);
        check_eq("t3_cpureset", {31'd0, CPUReset}, 32'd1);
        check_eq("t3_fertig", {31'd0, Fertig}, 32'd0);
        check_eq("t3_no_ramschreiben", wr_seen, 0);
        check_eq("t3_read_count", lesen_addr.size(), 1);

        // Slow RAM acknowledge: 5 waiting cycles per write
        sd_tab[0] = 32'd2;
        sd_tab[1] = 32'hDEAD_BEEF;
        sd_tab[2] = 32'h1234_5678;
        ram_delay = 5;
        do_reset("t4_reset");
        pulse_start();
        wait_state("t4_reach_fertig", FERTIG, 2000);
        check_writes("t4", 2, 32'hDEAD_BEEF);
        check_eq("t4_write_hold_cycles", last_hold, 6);
        check_eq("t4_fertig", {31'd0, Fertig}, 32'd1);

        // Reset during the second data write of N=4, then reload
        sd_tab[0] = 32'd4;
        sd_tab[1] = 32'h0000_0011;
        sd_tab[2] = 32'h0000_0022;
        sd_tab[3] = 32'h0000_0033;
        sd_tab[4] = 32'h0000_0044;
        ram_delay = 5;
        do_reset("t5_reset");
        pulse_start();
        for (int i = 0; i < 2000 && wr_addr.size() < 1; i++) @(negedge Clock);
        wait_state("t5_pause_after_w0", PAUSE, 200);
        wait_state("t5_second_write", RAM_SCHREIBEN, 200);
        check_eq("t5_write_active", {31'd0, bus.RAMSchreiben}, 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        repeat (2) @(negedge Clock);
        n_wr = wr_addr.size();
        n_rd = lesen_addr.size();
        check_eq("t5_writes_before_abort", n_wr, 1);
        Reset = 1'b1;
        repeat (100) @(negedge Clock);
        check_eq("t5_no_write_after_release", wr_addr.size(), n_wr);
        check_eq("t5_no_read_after_release", lesen_addr.size(), n_rd);
        check_eq("t5_idle_after_release", {29'd0, Zustand}, 32'd0);
        ram_delay = 0;
        clear_logs();
        pulse_start();
        wait_state("t5_reload_fertig", FERTIG, 3000);
        check_reads("t5_reload", 5);
        check_writes("t5_reload", 4, 32'h0000_0011);

        // Start pulsed repeatedly during a load
        sd_tab[0] = 32'd3;
        sd_tab[1] = 32'h0000_005A;
        sd_tab[2] = 32'h0000_006B;
        sd_tab[3] = 32'h0000_007C;
        do_reset("t6_reset");
        pulse_start();
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clock);
            if (Zustand == 3'd5) break;
            Start = (i % 5 == 0);
        end
        Start = 1'b0;
        check_eq("t6_reach_fertig", {29'd0, Zustand}, 32'd5);
        check_reads("t6", 4);
        check_writes("t6", 3, 32'h0000_005A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop so a stuck design can never hang the run
    initial begin
        #1000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
